// File: rtl/branch_predict_unit_pkg.sv
// Shared types for the fetch-side branch predictor: BTB entry layout,
// 2-bit direction counter encoding and the redirect/flush control types.
package branch_predict_unit_pkg;

  localparam int WORD      = 32;
  // Widest tag the BTB can need (BTB_ENTRIES = 2 leaves WORD-2 tag bits).
  localparam int TAG_MAX_W = WORD - 2;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } bp_counter;

  localparam bp_counter BP_CTR_RESET = WEAK_NT;
  localparam bp_counter BP_CTR_ALLOC = WEAK_T;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [WORD-1:0]      target;
    bp_counter            ctr;
  } btb_entry;

  typedef enum logic {
    NO_TAKE_BRANCH = 1'b0,
    TAKE_BRANCH    = 1'b1
  } take_branch_ctrl_sig;

  typedef enum logic {
    NO_FLUSH = 1'b0,
    FLUSH    = 1'b1
  } flush_pipeline_sig;

endpackage

// File: rtl/branch_predict_unit_btb_array.sv
// Direct-mapped BTB storage: combinational lookup port plus one training
// port with whole-array invalidate and saturating direction counters.
module branch_predict_unit_btb_array
  import branch_predict_unit_pkg::*;
#(
  parameter  int BTB_ENTRIES = 16,
  localparam int INDEX_BITS  = $clog2(BTB_ENTRIES),
  localparam int TAG_W       = WORD - 1 - INDEX_BITS
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [INDEX_BITS-1:0] rd_index_i,
  output btb_entry              rd_entry_o,
  input  logic                  upd_valid_i,
  input  logic [INDEX_BITS-1:0] upd_index_i,
  input  logic [TAG_W-1:0]      upd_tag_i,
  input  logic                  upd_taken_i,
  input  logic [WORD-1:0]       upd_target_i,
  input  logic                  invalidate_i
);

  logic [BTB_ENTRIES-1:0] valid_q, valid_d;
  bp_counter              ctr_q [BTB_ENTRIES];
  bp_counter              ctr_d [BTB_ENTRIES];
  logic [TAG_W-1:0]       tag_q [BTB_ENTRIES];
  logic [WORD-1:0]        target_q [BTB_ENTRIES];
  logic                   upd_hit;
  logic                   tt_we;

  function automatic bp_counter ctr_step(input bp_counter c, input logic taken);
    if (taken) return (c == STRONG_T)  ? STRONG_T  : bp_counter'(c + 2'd1);
    else       return (c == STRONG_NT) ? STRONG_NT : bp_counter'(c - 2'd1);
  endfunction

  always_comb begin
    rd_entry_o        = '0;
    rd_entry_o.valid  = valid_q[rd_index_i];
    rd_entry_o.tag    = TAG_MAX_W'(tag_q[rd_index_i]);
    rd_entry_o.target = target_q[rd_index_i];
    rd_entry_o.ctr    = ctr_q[rd_index_i];
  end

  assign upd_hit = valid_q[upd_index_i] && (tag_q[upd_index_i] == upd_tag_i);
  // Taken training writes tag/target both on a hit and on an allocation.
  assign tt_we   = upd_valid_i & ~invalidate_i & upd_taken_i;

  always_comb begin
    valid_d = valid_q;
    ctr_d   = ctr_q;
    if (invalidate_i) begin
      valid_d = '0;
    end else if (upd_valid_i) begin
      if (upd_hit) begin
        ctr_d[upd_index_i] = ctr_step(ctr_q[upd_index_i], upd_taken_i);
      end else if (upd_taken_i) begin
        valid_d[upd_index_i] = 1'b1;
        ctr_d[upd_index_i]   = BP_CTR_ALLOC;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      valid_q <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) ctr_q[i] <= BP_CTR_RESET;
    end else begin
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (tt_we) begin
      tag_q[upd_index_i]    <= upd_tag_i;
      target_q[upd_index_i] <= upd_target_i;
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Fetch-side branch predictor: BTB lookup for fetch, mispredict detection on
// resolved branches, one-cycle registered redirect/flush and statistics.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int BTB_ENTRIES = 16,
  parameter int CNT_W       = 16
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                fetch_valid_i,
  input  logic [WORD-1:0]     fetch_pc_i,
  output logic                predict_taken_o,
  output logic [WORD-1:0]     predict_target_o,
  input  logic                resolve_valid_i,
  input  logic [WORD-1:0]     resolve_pc_i,
  input  logic                resolve_taken_i,
  input  logic [WORD-1:0]     resolve_target_i,
  input  logic [WORD-1:0]     resolve_next_pc_i,
  input  logic                resolve_pred_taken_i,
  input  logic [WORD-1:0]     resolve_pred_target_i,
  input  logic                invalidate_i,
  output take_branch_ctrl_sig redirect_o,
  output logic [WORD-1:0]     redirect_pc_o,
  output flush_pipeline_sig   flush_pipeline_o,
  output logic [CNT_W-1:0]    branch_count_o,
  output logic [CNT_W-1:0]    mispredict_count_o
);

  localparam int INDEX_BITS = $clog2(BTB_ENTRIES);
  localparam int TAG_W      = WORD - 1 - INDEX_BITS;

  btb_entry            rd_entry;
  logic                fetch_hit;
  logic                accept;
  logic                mispredict;
  take_branch_ctrl_sig redirect_q, redirect_d;
  logic [WORD-1:0]     redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0]    branch_count_q, branch_count_d;
  logic [CNT_W-1:0]    mispredict_count_q, mispredict_count_d;
  logic                unused_pc_lsb;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // PCs are halfword aligned, so bit 0 never participates in index or tag.
  assign unused_pc_lsb = fetch_pc_i[0] ^ resolve_pc_i[0];

  branch_predict_unit_btb_array #(
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .rd_index_i   (fetch_pc_i[INDEX_BITS:1]),
    .rd_entry_o   (rd_entry),
    .upd_valid_i  (accept),
    .upd_index_i  (resolve_pc_i[INDEX_BITS:1]),
    .upd_tag_i    (resolve_pc_i[WORD-1:INDEX_BITS+1]),
    .upd_taken_i  (resolve_taken_i),
    .upd_target_i (resolve_target_i),
    .invalidate_i (invalidate_i)
  );

  assign fetch_hit = rd_entry.valid &&
                     (rd_entry.tag == TAG_MAX_W'(fetch_pc_i[WORD-1:INDEX_BITS+1]));

  always_comb begin
    predict_taken_o  = fetch_valid_i & fetch_hit &
                       ((rd_entry.ctr == WEAK_T) || (rd_entry.ctr == STRONG_T));
    predict_target_o = fetch_hit ? rd_entry.target : '0;
  end

  // A resolve arriving while the redirect is out is on the wrong path.
  assign accept     = resolve_valid_i & (redirect_q == NO_TAKE_BRANCH);
  assign mispredict = (resolve_taken_i != resolve_pred_taken_i) |
                      (resolve_taken_i & (resolve_target_i != resolve_pred_target_i));

  always_comb begin
    redirect_d         = NO_TAKE_BRANCH;
    redirect_pc_d      = '0;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (accept) begin
      branch_count_d = sat_inc(branch_count_q);
      if (mispredict) begin
        redirect_d         = TAKE_BRANCH;
        redirect_pc_d      = resolve_taken_i ? resolve_target_i : resolve_next_pc_i;
        mispredict_count_d = sat_inc(mispredict_count_q);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      redirect_q         <= NO_TAKE_BRANCH;
      redirect_pc_q      <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      redirect_q         <= redirect_d;
      redirect_pc_q      <= redirect_pc_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign redirect_o         = redirect_q;
  assign redirect_pc_o      = redirect_pc_q;
  assign flush_pipeline_o   = (redirect_q == TAKE_BRANCH) ? FLUSH : NO_FLUSH;
  assign branch_count_o     = branch_count_q;
  assign mispredict_count_o = mispredict_count_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Bench for branch_predict_unit: directed scenarios followed by random
// traffic, checked against a behavioural BTB model.
module tb_branch_predict_unit;
  import branch_predict_unit_pkg::*;

  localparam int N  = 16;
  localparam int IB = 4;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic                clk_i, reset_i;
  logic                fetch_valid_i;
  logic [31:0]         fetch_pc_i;
  logic                predict_taken_o;
  logic [31:0]         predict_target_o;
  logic                resolve_valid_i, resolve_taken_i, resolve_pred_taken_i;
  logic [31:0]         resolve_pc_i, resolve_target_i, resolve_next_pc_i, resolve_pred_target_i;
  logic                invalidate_i;
  take_branch_ctrl_sig redirect_o;
  logic [31:0]         redirect_pc_o;
  flush_pipeline_sig   flush_pipeline_o;
  logic [CW-1:0]       branch_count_o, mispredict_count_o;

  branch_predict_unit #(.BTB_ENTRIES(N), .CNT_W(CW)) dut (
    .clk_i                 (clk_i),
    .reset_i               (reset_i),
    .fetch_valid_i         (fetch_valid_i),
    .fetch_pc_i            (fetch_pc_i),
    .predict_taken_o       (predict_taken_o),
    .predict_target_o      (predict_target_o),
    .resolve_valid_i       (resolve_valid_i),
    .resolve_pc_i          (resolve_pc_i),
    .resolve_taken_i       (resolve_taken_i),
    .resolve_target_i      (resolve_target_i),
    .resolve_next_pc_i     (resolve_next_pc_i),
    .resolve_pred_taken_i  (resolve_pred_taken_i),
    .resolve_pred_target_i (resolve_pred_target_i),
    .invalidate_i          (invalidate_i),
    .redirect_o            (redirect_o),
    .redirect_pc_o         (redirect_pc_o),
    .flush_pipeline_o      (flush_pipeline_o),
    .branch_count_o        (branch_count_o),
    .mispredict_count_o    (mispredict_count_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk, n_fail;

  // Reference model state
  bit          m_valid [N];
  logic [31:0] m_tag   [N];
  logic [31:0] m_tgt   [N];
  int          m_ctr   [N];
  bit          m_redir;
  logic [31:0] m_rpc;
  int          m_bc, m_mc;

  logic        obs_pt;
  logic [31:0] obs_ptg;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 1) & (N - 1));
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc >> (IB + 1);
  endfunction

  function automatic logic [31:0] rand_pc();
    return 32'h0001_0000 | ($urandom_range(0, 3) << 5) | ($urandom_range(0, 15) << 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0;
      m_ctr[i]   = 1;
    end
    m_redir = 0; m_rpc = 0; m_bc = 0; m_mc = 0;
  endtask

  task automatic idle_inputs();
    fetch_valid_i = 0; fetch_pc_i = 0;
    resolve_valid_i = 0; resolve_pc_i = 0; resolve_taken_i = 0;
    resolve_target_i = 0; resolve_next_pc_i = 0;
    resolve_pred_taken_i = 0; resolve_pred_target_i = 0;
    invalidate_i = 0;
  endtask

  task automatic check_regs(input string pfx);
    check({pfx, "_redirect"}, redirect_o, m_redir);
    check({pfx, "_flush"}, flush_pipeline_o, m_redir);
    check({pfx, "_redirect_pc"}, redirect_pc_o, m_rpc);
    check({pfx, "_branch_cnt"}, branch_count_o, m_bc);
    check({pfx, "_mispred_cnt"}, mispredict_count_o, m_mc);
  endtask

  // One clock: drive, check lookup before the edge, advance model, check registers.
  task automatic do_cycle(input bit fv, input logic [31:0] fpc,
                          input bit rv, input logic [31:0] rpc, input bit rt,
                          input logic [31:0] rtgt, input logic [31:0] rnext,
                          input bit rpt, input logic [31:0] rptgt, input bit inv);
    int  i, j;
    bit  hit, hj, acc, mis;
    fetch_valid_i = fv; fetch_pc_i = fpc;
    resolve_valid_i = rv; resolve_pc_i = rpc; resolve_taken_i = rt;
    resolve_target_i = rtgt; resolve_next_pc_i = rnext;
    resolve_pred_taken_i = rpt; resolve_pred_target_i = rptgt;
    invalidate_i = inv;
    #2;
    i   = idx_of(fpc);
    hit = m_valid[i] && (m_tag[i] == tag_of(fpc));
    obs_pt  = predict_taken_o;
    obs_ptg = predict_target_o;
    check("pred_taken", predict_taken_o, (fv && hit && m_ctr[i] >= 2));
    check("pred_target", predict_target_o, hit ? m_tgt[i] : 32'h0);
    acc = rv && !m_redir;
    mis = (rt != rpt) || (rt && (rtgt != rptgt));
    @(posedge clk_i);
    #1;
    if (acc) begin
      if (m_bc < CMAX) m_bc++;
      if (mis && m_mc < CMAX) m_mc++;
    end
    if (inv) begin
      for (int k = 0; k < N; k++) m_valid[k] = 0;
    end else if (acc) begin
      j  = idx_of(rpc);
      hj = m_valid[j] && (m_tag[j] == tag_of(rpc));
      if (hj) begin
        if (rt) begin
          if (m_ctr[j] < 3) m_ctr[j]++;
          m_tgt[j] = rtgt;
        end else if (m_ctr[j] > 0) m_ctr[j]--;
      end else if (rt) begin
        m_valid[j] = 1; m_tag[j] = tag_of(rpc); m_tgt[j] = rtgt; m_ctr[j] = 2;
      end
    end
    m_redir = acc && mis;
    m_rpc   = m_redir ? (rt ? rtgt : rnext) : 32'h0;
    check_regs("cyc");
    idle_inputs();
  endtask

  initial begin
    int bc_save;
    n_chk = 0; n_fail = 0;
    clk_i = 0; reset_i = 0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i) reset_i = 1;
    @(posedge clk_i);
    #1;

    // Step 1: state straight out of reset
    fetch_valid_i = 1; fetch_pc_i = 32'h100;
    #1;
    check("s1_pred_taken", predict_taken_o, 0);
    check("s1_pred_target", predict_target_o, 32'h0);
    check("s1_redirect", redirect_o, 0);
    check("s1_branch_cnt", branch_count_o, 0);
    check("s1_mispred_cnt", mispredict_count_o, 0);
    do_cycle(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);

    // Step 2: taken miss allocates and redirects
    do_cycle(1, 32'h100, 1, 32'h100, 1, 32'h140, 32'h104, 0, 32'h0, 0);
    check("s2_redirect", redirect_o, 1);
    check("s2_redirect_pc", redirect_pc_o, 32'h140);
    check("s2_flush", flush_pipeline_o, 1);
    check("s2_mispred_cnt", mispredict_count_o, 1);
    do_cycle(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
    check("s2_fetch_taken", obs_pt, 1);
    check("s2_fetch_target", obs_ptg, 32'h140);
    check("s2_redirect_drop", redirect_o, 0);

    // Step 3: not-taken mispredict weakens the counter
    do_cycle(0, 0, 1, 32'h100, 0, 32'h0, 32'h102, 1, 32'h140, 0);
    check("s3_redirect_pc", redirect_pc_o, 32'h102);
    do_cycle(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
    check("s3_fetch_taken", obs_pt, 0);

    // Step 4: strengthen, then alias-replace at the same index
    do_cycle(0, 0, 1, 32'h100, 1, 32'h140, 32'h102, 0, 32'h0, 0);
    do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_cycle(0, 0, 1, 32'h100, 1, 32'h140, 32'h102, 1, 32'h140, 0);
    check("s4_no_redirect", redirect_o, 0);
    do_cycle(1, 32'h120, 0, 0, 0, 0, 0, 0, 0, 0);
    check("s4_alias_taken", obs_pt, 0);
    do_cycle(0, 0, 1, 32'h120, 1, 32'h200, 32'h122, 0, 32'h0, 0);
    do_cycle(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
    check("s4_old_taken", obs_pt, 0);
    check("s4_old_target", obs_ptg, 32'h0);
    do_cycle(1, 32'h120, 0, 0, 0, 0, 0, 0, 0, 0);
    check("s4_new_target", obs_ptg, 32'h200);

    // Step 5: resolve during the redirect cycle is dropped
    do_cycle(0, 0, 1, 32'h130, 1, 32'h300, 32'h132, 0, 32'h0, 0);
    bc_save = m_bc;
    do_cycle(1, 32'h130, 1, 32'h130, 0, 32'h0, 32'h132, 1, 32'h300, 0);
    check("s5_no_second_redirect", redirect_o, 0);
    check("s5_branch_cnt_held", branch_count_o, bc_save);
    do_cycle(1, 32'h130, 0, 0, 0, 0, 0, 0, 0, 0);
    check("s5_btb_unchanged", obs_pt, 1);

    // Step 6: asynchronous reset with a redirect outstanding
    do_cycle(0, 0, 1, 32'h130, 0, 32'h0, 32'h134, 1, 32'h300, 0);
    check("s6_redirect_pending", redirect_o, 1);
    #2 reset_i = 0;
    #1;
    model_reset();
    check("s6_redirect_rst", redirect_o, 0);
    check("s6_flush_rst", flush_pipeline_o, 0);
    check("s6_redirect_pc_rst", redirect_pc_o, 32'h0);
    check("s6_branch_cnt_rst", branch_count_o, 0);
    check("s6_mispred_cnt_rst", mispredict_count_o, 0);
    @(negedge clk_i) reset_i = 1;
    @(posedge clk_i);
    #1;
    do_cycle(1, 32'h120, 0, 0, 0, 0, 0, 0, 0, 0);
    check("s6_trained_lost", obs_pt, 0);

    // Invalidate wins over training; statistics still count
    do_cycle(0, 0, 1, 32'h140, 1, 32'h500, 32'h142, 0, 32'h0, 1);
    do_cycle(1, 32'h140, 0, 0, 0, 0, 0, 0, 0, 0);
    check("inv_no_alloc", obs_pt, 0);

    // Random traffic; statistics saturate early with the narrow counters
    for (int k = 0; k < 400; k++) begin
      logic [31:0] fpc, rpc, rtgt, rptgt;
      bit          rv, rt, rpt;
      int          j;
      fpc  = rand_pc();
      rpc  = rand_pc();
      rv   = ($urandom_range(0, 2) != 0);
      rt   = ($urandom_range(0, 1) != 0);
      rtgt = 32'h400 + ($urandom_range(0, 3) << 4);
      j    = idx_of(rpc);
      if (m_valid[j] && (m_tag[j] == tag_of(rpc))) begin
        rpt = (m_ctr[j] >= 2); rptgt = m_tgt[j];
      end else begin
        rpt = 0; rptgt = 32'h0;
      end
      if ($urandom_range(0, 3) == 0) rpt = ~rpt;
      do_cycle(($urandom_range(0, 3) != 0), fpc, rv, rpc, rt, rtgt, rpc + 32'h2,
               rpt, rptgt, ($urandom_range(0, 49) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
